collision_monitor: RTL

Per-frame collision statistics collector for the rasteriser output stage. Each pixel cycle it samples the per-component enable vector, treats any pixel where two or more components drive output at once as a collision, and accumulates count, peak overlap and participating-component mask over the frame. At frame end it latches a report and presents it to the host/CPU side over a valid/ready handshake.

---
 rtl/gpu_collision_pkg.sv | 26 ++
 rtl/enable_popcount.sv | 29 ++
 rtl/collision_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gpu_collision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_collision_pkg
// Description : Shared types and helpers for the rasteriser collision
//               monitor: report-register state encoding, width helper for
//               overlap counts and the default collision counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_collision_pkg;

    // Default width of the per-frame collision pixel counter.
    localparam int c_default_cnt_w = 16;

    // Report register occupancy.
    typedef enum logic [0:0] {
        REP_EMPTY = 1'b0,
        REP_FULL  = 1'b1
    } rep_state_t;

    // Bits needed to hold a count of 0..width simultaneously active components.
    function automatic int max_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : gpu_collision_pkg
`default_nettype wire

// File: rtl/enable_popcount.sv
`default_nettype none
// ============================================================================
// Module      : enable_popcount
// Description : Combinational population count of the per-component enable
//               array.
// Ports       : enable [WIDTH-1:0] in  - per-component active flags
//               count             out - number of set flags
// Revision    : 1.0 - initial release
// ============================================================================
module enable_popcount
    import gpu_collision_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                          enable [WIDTH-1:0],
    output logic [max_width(WIDTH)-1:0]   count
);

    localparam int c_cnt_w = max_width(WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {{(c_cnt_w-1){1'b0}}, enable[i]};
        end
    end

endmodule : enable_popcount
`default_nettype wire

// File: rtl/collision_monitor.sv
`default_nettype none
// ============================================================================
// Module      : collision_monitor
// Description : Per-frame collision statistics collector. A pixel on which
//               two or more components are enabled is a collision; the frame
//               accumulates collision count (saturating), peak overlap and the
//               mask of participating components. At frame end the totals are
//               latched into a one-entry report register read by the host via
//               valid/ready.
// Ports       : clk, reset (async, active-high)
//               enable [WIDTH-1:0] in  - per-component active flags
//               pixel_valid        in  - enable vector meaningful this cycle
//               frame_end          in  - last cycle of the frame
//               report_valid       out - report holds a completed frame
//               report_ready       in  - host accepts report
//               report_pixels      out - collision pixel count (saturating)
//               report_max         out - peak simultaneous enable count
//               report_mask        out - OR of enables over collision pixels
//               report_overflow    out - report_pixels saturated
//               report_lost        out - an earlier report was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module collision_monitor
    import gpu_collision_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable [WIDTH-1:0],
    input  logic                          pixel_valid,
    input  logic                          frame_end,
    output logic                          report_valid,
    input  logic                          report_ready,
    output logic [CNT_W-1:0]              report_pixels,
    output logic [max_width(WIDTH)-1:0]   report_max,
    output logic [WIDTH-1:0]              report_mask,
    output logic                          report_overflow,
    output logic                          report_lost
);

    localparam int                 c_max_w = max_width(WIDTH);
    localparam logic [c_max_w-1:0] c_two   = c_max_w'(2);

    // ------------------------------------------------------------------
    // Stage 1: popcount and registered copy of the pixel
    // ------------------------------------------------------------------
    logic [c_max_w-1:0] w_pop;
    logic [WIDTH-1:0]   w_en_packed;

    enable_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .enable (enable),
        .count  (w_pop)
    );

    always_comb begin
        w_en_packed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_en_packed[i] = enable[i];
        end
    end

    logic [c_max_w-1:0] r_s1_pop;
    logic [WIDTH-1:0]   r_s1_en;
    logic               r_s1_valid;
    logic               r_s1_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_pop   <= '0;
            r_s1_en    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_end   <= 1'b0;
        end else begin
            // Invalid pixels carry a zero count so they never raise the peak.
            r_s1_pop   <= pixel_valid ? w_pop : '0;
            r_s1_en    <= w_en_packed;
            r_s1_valid <= pixel_valid;
            r_s1_end   <= frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: frame accumulator
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   r_acc_pixels;
    logic               r_acc_ovf;
    logic [WIDTH-1:0]   r_acc_mask;
    logic [c_max_w-1:0] r_acc_max;

    logic               w_coll;
    logic               w_sat;
    logic [CNT_W-1:0]   w_snap_pixels;
    logic               w_snap_ovf;
    logic [WIDTH-1:0]   w_snap_mask;
    logic [c_max_w-1:0] w_snap_max;

    // The snapshot already includes the pixel currently in stage 1, so a
    // pixel arriving together with frame_end is counted in the ending frame.
    always_comb begin
        w_coll        = r_s1_valid && (r_s1_pop >= c_two);
        w_sat         = (r_acc_pixels == {CNT_W{1'b1}});
        w_snap_pixels = (w_coll && !w_sat) ? r_acc_pixels + CNT_W'(1) : r_acc_pixels;
        w_snap_ovf    = r_acc_ovf | (w_coll & w_sat);
        w_snap_mask   = w_coll ? (r_acc_mask | r_s1_en) : r_acc_mask;
        w_snap_max    = (r_s1_valid && (r_s1_pop > r_acc_max)) ? r_s1_pop : r_acc_max;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_pixels <= '0;
            r_acc_ovf    <= 1'b0;
            r_acc_mask   <= '0;
            r_acc_max    <= '0;
        end else if (r_s1_end) begin
            r_acc_pixels <= '0;
            r_acc_ovf    <= 1'b0;
            r_acc_mask   <= '0;
            r_acc_max    <= '0;
        end else begin
            r_acc_pixels <= w_snap_pixels;
            r_acc_ovf    <= w_snap_ovf;
            r_acc_mask   <= w_snap_mask;
            r_acc_max    <= w_snap_max;
        end
    end

    // ------------------------------------------------------------------
    // Report register FSM
    // ------------------------------------------------------------------
    rep_state_t r_state;
    rep_state_t w_state_next;
    logic       w_load;
    logic       r_lost_pending;
    logic       w_lost_pending_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= REP_EMPTY;
            r_lost_pending <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_lost_pending <= w_lost_pending_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_load              = 1'b0;
        w_lost_pending_next = r_lost_pending;
        case (r_state)
            REP_EMPTY: begin
                if (r_s1_end) begin
                    w_load              = 1'b1;
                    w_lost_pending_next = 1'b0;
                    w_state_next        = REP_FULL;
                end
            end
            REP_FULL: begin
                if (r_s1_end) begin
                    if (report_ready) begin
                        // Host takes the old report on the same edge the new
                        // one lands: refill without a bubble.
                        w_load              = 1'b1;
                        w_lost_pending_next = 1'b0;
                    end else begin
                        // Unread report is kept; the new frame is dropped.
                        w_lost_pending_next = 1'b1;
                    end
                end else if (report_ready) begin
                    w_state_next = REP_EMPTY;
                end
            end
            default: begin
                w_state_next = REP_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            report_pixels   <= '0;
            report_max      <= '0;
            report_mask     <= '0;
            report_overflow <= 1'b0;
            report_lost     <= 1'b0;
        end else if (w_load) begin
            report_pixels   <= w_snap_pixels;
            report_max      <= w_snap_max;
            report_mask     <= w_snap_mask;
            report_overflow <= w_snap_ovf;
            report_lost     <= r_lost_pending;
        end
    end

    assign report_valid = (r_state == REP_FULL);

endmodule : collision_monitor
`default_nettype wire
